// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - decode-stage controller with 2-slot skid buffer and registered decode bundle (optional DECODE_CTRL_PERF_EN perf counters)
module decode_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [6:0]      out_opcode,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic            out_reg_we,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_branch,
    output logic            out_jump,
`ifdef DECODE_CTRL_PERF_EN
    output logic            out_illegal,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_issue_cnt
`else
    output logic            out_illegal
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    // Decode bundle layout: {fmt[2:0], reg_we, mem_rd, mem_wr, branch, jump, illegal}
    localparam logic [8:0] DEC_RESET = {FMT_NONE, 6'b000000};

    // Classify one instruction word into format and control strobes
    function automatic logic [8:0] decode(input logic [31:0] inst);
        logic [8:0] d;
        d = {FMT_NONE, 6'b000001};
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                7'b0110011: d = {FMT_R, 6'b100000};
                7'b0010011: d = {FMT_I, 6'b100000};
                7'b0000011: d = {FMT_I, 6'b110000};
                7'b1100111: d = {FMT_I, 6'b100010};
                7'b0100011: d = {FMT_S, 6'b001000};
                7'b1100011: d = {FMT_B, 6'b000100};
                7'b0110111: d = {FMT_U, 6'b100000};
                7'b0010111: d = {FMT_U, 6'b100000};
                7'b1101111: d = {FMT_J, 6'b100010};
                7'b0001111: d = {FMT_I, 6'b000000};
                7'b1110011: d = {FMT_I, 6'b000000};
                default:    d = {FMT_NONE, 6'b000001};
            endcase
        end
        return d;
    endfunction

    state_t          state;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_pc;
    logic [8:0]      skid_dec;
    logic [8:0]      in_dec;
    logic [8:0]      main_dec;

    // Decode happens on the incoming word so both slots hold finished results
    assign in_dec = decode(in_inst);

    // Main slot fields drive the outputs directly
    assign {out_fmt, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal} = main_dec;
    assign out_opcode = out_inst[6:0];

    // Occupancy FSM: moves entries between input, skid and main slots; flush only clears valid state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_inst  <= '0;
            out_pc    <= RESET_PC;
            main_dec  <= DEC_RESET;
            skid_inst <= '0;
            skid_pc   <= RESET_PC;
            skid_dec  <= DEC_RESET;
        end else if (flush) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_valid) begin
                        out_inst  <= in_inst;
                        out_pc    <= in_pc;
                        main_dec  <= in_dec;
                        state     <= S_ONE;
                        out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_valid && out_ready) begin
                        out_inst <= in_inst;
                        out_pc   <= in_pc;
                        main_dec <= in_dec;
                    end else if (out_ready) begin
                        state     <= S_EMPTY;
                        out_valid <= 1'b0;
                    end else if (in_valid) begin
                        skid_inst <= in_inst;
                        skid_pc   <= in_pc;
                        skid_dec  <= in_dec;
                        state     <= S_TWO;
                        in_ready  <= 1'b0;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so any in_valid is not a transfer
                    if (out_ready) begin
                        out_inst <= skid_inst;
                        out_pc   <= skid_pc;
                        main_dec <= skid_dec;
                        state    <= S_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef DECODE_CTRL_PERF_EN
    // Stall and issue counters; free-running wrap, unaffected by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_issue_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (out_valid && out_ready) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// tb/tb_decode_ctrl.sv - table-driven self-checking bench for decode_ctrl
module tb_decode_ctrl;

    localparam logic [31:0] PC_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [6:0]  out_opcode;
    logic [31:0] out_pc;
    logic [2:0]  out_fmt;
    logic        out_reg_we;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        out_branch;
    logic        out_jump;
    logic        out_illegal;
`ifdef DECODE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_issue_cnt;
`endif

    int passed = 0;
    int total  = 0;

    decode_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_opcode  (out_opcode),
        .out_pc      (out_pc),
        .out_fmt     (out_fmt),
        .out_reg_we  (out_reg_we),
        .out_mem_rd  (out_mem_rd),
        .out_mem_wr  (out_mem_wr),
        .out_branch  (out_branch),
`ifdef DECODE_CTRL_PERF_EN
        .out_jump    (out_jump),
        .out_illegal (out_illegal),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_issue_cnt (perf_issue_cnt)
`else
        .out_jump    (out_jump),
        .out_illegal (out_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic        ordy;
        logic        fl;
        logic [10:0] ectl;   // {out_valid, in_ready, fmt[2:0], we, rd, wr, br, jp, ill}
        logic [31:0] einst;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] ctl_now();
        return {out_valid, in_ready, out_fmt, out_reg_we, out_mem_rd, out_mem_wr,
                out_branch, out_jump, out_illegal};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] inst, input logic ordy, input logic fl,
                       input logic ov, input logic ir, input logic [2:0] fmt,
                       input logic [5:0] strobes, input logic [31:0] einst);
        vec_t v;
        v.iv    = iv;
        v.inst  = inst;
        v.ordy  = ordy;
        v.fl    = fl;
        v.ectl  = {ov, ir, fmt, strobes};
        v.einst = einst;
        vecs.push_back(v);
    endtask

    // strobes field: {we, rd, wr, br, jp, ill}
    initial begin
        // stream with out_ready=1
        add(1, 32'h00500093, 1, 0, 1, 1, 3'd1, 6'b100000, 32'h00500093);
        add(1, 32'h00112023, 1, 0, 1, 1, 3'd2, 6'b001000, 32'h00112023);
        add(1, 32'hFE000EE3, 1, 0, 1, 1, 3'd3, 6'b000100, 32'hFE000EE3);
        add(1, 32'h000012B7, 1, 0, 1, 1, 3'd4, 6'b100000, 32'h000012B7);
        add(0, 32'h00000000, 1, 0, 0, 1, 3'd4, 6'b100000, 32'h000012B7);
        // backpressure: third push refused, then FIFO drain
        add(1, 32'h00500093, 0, 0, 1, 1, 3'd1, 6'b100000, 32'h00500093);
        add(1, 32'h00112023, 0, 0, 1, 0, 3'd1, 6'b100000, 32'h00500093);
        add(1, 32'h008000EF, 0, 0, 1, 0, 3'd1, 6'b100000, 32'h00500093);
        add(0, 32'h00000000, 1, 0, 1, 1, 3'd2, 6'b001000, 32'h00112023);
        add(0, 32'h00000000, 1, 0, 0, 1, 3'd2, 6'b001000, 32'h00112023);
        // flush in TWO with a simultaneous input beat
        add(1, 32'h00500093, 0, 0, 1, 1, 3'd1, 6'b100000, 32'h00500093);
        add(1, 32'h00112023, 0, 0, 1, 0, 3'd1, 6'b100000, 32'h00500093);
        add(1, 32'h008000EF, 0, 1, 0, 1, 3'd1, 6'b100000, 32'h00500093);
        add(0, 32'h00000000, 1, 0, 0, 1, 3'd1, 6'b100000, 32'h00500093);
        // illegal and remaining opcode classes
        add(1, 32'h0000007F, 1, 0, 1, 1, 3'd7, 6'b000001, 32'h0000007F);
        add(1, 32'h00000010, 1, 0, 1, 1, 3'd7, 6'b000001, 32'h00000010);
        add(1, 32'h008000EF, 1, 0, 1, 1, 3'd5, 6'b100010, 32'h008000EF);
        add(1, 32'h00002003, 1, 0, 1, 1, 3'd1, 6'b110000, 32'h00002003);
        add(1, 32'h000000E7, 1, 0, 1, 1, 3'd1, 6'b100010, 32'h000000E7);
        add(1, 32'h00000073, 1, 0, 1, 1, 3'd1, 6'b000000, 32'h00000073);
        add(1, 32'h00000033, 1, 0, 1, 1, 3'd0, 6'b100000, 32'h00000033);
        add(1, 32'h0000000F, 1, 0, 1, 1, 3'd1, 6'b000000, 32'h0000000F);
        add(1, 32'h00000017, 1, 0, 1, 1, 3'd4, 6'b100000, 32'h00000017);
        add(0, 32'h00000000, 1, 0, 0, 1, 3'd4, 6'b100000, 32'h00000017);
        // flush in ONE with a simultaneous output transfer
        add(1, 32'h00000013, 0, 0, 1, 1, 3'd1, 6'b100000, 32'h00000013);
        add(0, 32'h00000000, 1, 1, 0, 1, 3'd1, 6'b100000, 32'h00000013);
        // leave one entry buffered for the mid-operation reset
        add(1, 32'h00000033, 0, 0, 1, 1, 3'd0, 6'b100000, 32'h00000033);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ctl", 64'(ctl_now()), 64'({1'b0, 1'b1, 3'd7, 6'b000000}));
        check("reset_inst", 64'(out_inst), 64'h0);
        check("reset_pc", 64'(out_pc), 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            in_inst   = vecs[i].inst;
            in_pc     = vecs[i].inst ^ PC_KEY;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ctl", i), 64'(ctl_now()), 64'(vecs[i].ectl));
            check($sformatf("v%0d_inst", i), 64'(out_inst), 64'(vecs[i].einst));
            check($sformatf("v%0d_opcode", i), 64'(out_opcode), 64'(vecs[i].einst[6:0]));
            check($sformatf("v%0d_pc", i), 64'(out_pc), 64'(vecs[i].einst ^ PC_KEY));
        end

        // asynchronous reset mid-operation, checked before any clock edge
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst_ctl", 64'(ctl_now()), 64'({1'b0, 1'b1, 3'd7, 6'b000000}));
        check("midrst_inst", 64'(out_inst), 64'h0);
        check("midrst_pc", 64'(out_pc), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_valid", 64'(out_valid), 64'h0);

`ifdef DECODE_CTRL_PERF_EN
        // one push, five stalled cycles, then three issues
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00000033; out_ready = 1'b1;
        @(negedge clk);
        in_inst = 32'h00000037;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("perf_stall", 64'(perf_stall_cnt), 64'd5);
        check("perf_issue", 64'(perf_issue_cnt), 64'd3);
        check("perf_empty", 64'(out_valid), 64'h0);
        // flush leaves the counters alone; wrap from all ones
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("perf_flush_keep", 64'(perf_issue_cnt), 64'd3);
        force dut.perf_issue_cnt = 32'hFFFF_FFFF;
        force dut.perf_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.perf_issue_cnt;
        release dut.perf_stall_cnt;
        in_valid = 1'b1; in_inst = 32'h00000013; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("perf_stall_wrap", 64'(perf_stall_cnt), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("perf_issue_wrap", 64'(perf_issue_cnt), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Decode-stage controller between instruction fetch and execute.
- Accepts instruction words over a valid/ready handshake and buffers them in a 2-slot skid buffer.
- Classifies each opcode into an immediate format, and drives the opcode/instruction into the immediate generator.
- Emits a registered decoded bundle (format, control strobes, illegal flag) to execute, with backpressure and pipeline flush.

Parameters:
- XLEN, 32, width of PC field carried with each instruction.
- RESET_PC, 32'h0000_0000, value driven on out_pc while empty after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  decode can accept this cycle.
- in_inst  input  32  instruction word.
- in_pc  input  XLEN  PC of in_inst.
- flush  input  1  discard all buffered instructions (branch redirect).
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- out_inst  output  32  buffered instruction; feeds the immediate generator instIn.
- out_opcode  output  7  out_inst[6:0]; feeds the immediate generator opcode.
- out_pc  output  XLEN  PC of out_inst.
- out_fmt  output  3  0=R,1=I,2=S,3=B,4=U,5=J,7=none.
- out_reg_we  output  1  instruction writes rd.
- out_mem_rd  output  1  load.
- out_mem_wr  output  1  store.
- out_branch  output  1  conditional branch.
- out_jump  output  1  JAL/JALR.
- out_illegal  output  1  unsupported opcode or inst[1:0]!=2'b11.

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - rst_n asynchronous assert, synchronous deassert handled upstream.
  - Reset values: out_valid=0, in_ready=1, out_inst=0, out_pc=RESET_PC, out_fmt=7, all strobes 0.
- Storage:
  - Main slot drives all out_* signals.
  - Skid slot holds one extra entry.
  - Both slots store instruction, PC and the precomputed decode fields, so every output is a register.
- Occupancy state machine:
  - EMPTY: in_valid → ONE.
  - ONE: in_valid & out_ready → ONE (replace main); out_ready only → EMPTY; in_valid only → TWO.
  - TWO: out_ready → ONE (skid moves to main); otherwise hold.
- Handshakes:
  - in_ready = 1 in EMPTY/ONE, 0 in TWO. It is registered and does not depend combinationally on out_ready.
  - out_valid = 1 in ONE/TWO.
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency and throughput:
  - Accept-to-out_valid latency is 1 cycle.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
  - Order is strictly FIFO.
- Decode is computed on in_inst at capture:
  - 0110011 → R, reg_we.
  - 0010011 → I, reg_we.
  - 0000011 → I, reg_we, mem_rd.
  - 1100111 → I, reg_we, jump.
  - 0100011 → S, mem_wr.
  - 1100011 → B, branch.
  - 0110111 and 0010111 → U, reg_we.
  - 1101111 → J, reg_we, jump.
  - 0001111 and 1110011 → I, no strobes.
  - Anything else, or inst[1:0]!=2'b11 → fmt=7, illegal=1, all other strobes 0.
- Flush:
  - Highest priority. On the cycle flush=1, both slots are invalidated at the next edge and state → EMPTY.
  - An input transferred in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as consumed.
  - Data registers keep their values; only valid bits clear.
- Payload stability: while out_valid=1 and out_ready=0, all out_* remain stable.
- Reset mid-operation: immediate return to reset values; buffered entries are lost.

Optional Feature:
- Macro: DECODE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_issue_cnt[31:0], both reset to 0.
  - perf_stall_cnt increments each cycle out_valid & !out_ready.
  - perf_issue_cnt increments each output transfer.
  - Both wrap 32'hFFFF_FFFF → 0.
  - Flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, rst_n low then high, no stimulus → out_valid=0, in_ready=1, out_fmt=7, out_pc=RESET_PC.
- Stream with out_ready=1: in_inst 0x00500093, 0x00112023, 0xFE000EE3, 0x000012B7 → out_fmt 1,2,3,4 one cycle after each accept; reg_we 1,0,0,1; mem_wr on the second only.
- Backpressure: out_ready=0, push 3 instructions → first two accepted, in_ready=0 after the second, out_inst holds the first. Raise out_ready → drains in order, in_ready back to 1 one cycle later.
- Flush in TWO with simultaneous in_valid → next cycle out_valid=0, EMPTY; the input beat is not seen at the output.
- Illegal: in_inst 0x0000007F and 0x00000013 with bits[1:0] forced to 2'b00 → out_illegal=1, fmt=7, strobes 0. JAL 0x008000EF → fmt=5, jump=1, reg_we=1.
- With DECODE_CTRL_PERF_EN: hold out_ready=0 for 5 valid cycles, then issue 3 → perf_stall_cnt=5, perf_issue_cnt=3. Preload near wrap via force → wraps to 0.
